// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte-lane write masks, per-port enables, selectable
// read-during-write mode, 1/2-cycle read latency and cross-port collision counting.
module dp_ram_be #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned NB        = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en1_i,
    input  logic [NB-1:0]         we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wr_data1_i,
    output logic [DATA_WIDTH-1:0] rd_data1_o,
    output logic                  rd_valid1_o,
    input  logic                  en2_i,
    input  logic [NB-1:0]         we2_i,
    input  logic [ADDR_WIDTH-1:0] addr2_i,
    input  logic [DATA_WIDTH-1:0] wr_data2_i,
    output logic [DATA_WIDTH-1:0] rd_data2_o,
    output logic                  rd_valid2_o,
    output logic                  collision_o,
    output logic [CNT_WIDTH-1:0]  coll_cnt_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if ((RD_LATENCY != 1 && RD_LATENCY != 2) || (DATA_WIDTH % BYTE_WIDTH != 0)) begin : g_param_check
        $error("dp_ram_be: RD_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] old1_s, old2_s, word1_s, word2_s, resp1_s, resp2_s;
    logic                  same_s, wr1_s, wr2_s, coll_s;

    logic [DATA_WIDTH-1:0] s1_data1_q, s1_data2_q;
    logic                  s1_valid1_q, s1_valid2_q;
    logic                  collision_q;
    logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;

    // Lane merge: on a shared address port 2 lanes override port 1 lanes, so both
    // ports compute the identical final word and the double write is harmless.
    always_comb begin
        old1_s  = mem_q[addr1_i];
        old2_s  = mem_q[addr2_i];
        same_s  = (addr1_i == addr2_i);
        wr1_s   = en1_i && (we1_i != {NB{1'b0}});
        wr2_s   = en2_i && (we2_i != {NB{1'b0}});
        word1_s = old1_s;
        word2_s = old2_s;
        for (int b = 0; b < int'(NB); b++) begin
            if (same_s && en2_i && we2_i[b]) begin
                word1_s[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data2_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (we1_i[b]) begin
                word1_s[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data1_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                word1_s[b*BYTE_WIDTH +: BYTE_WIDTH] = old1_s[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (we2_i[b]) begin
                word2_s[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data2_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (same_s && en1_i && we1_i[b]) begin
                word2_s[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data1_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                word2_s[b*BYTE_WIDTH +: BYTE_WIDTH] = old2_s[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        resp1_s = (RDW_MODE == 1 && wr1_s) ? word1_s : old1_s;
        resp2_s = (RDW_MODE == 1 && wr2_s) ? word2_s : old2_s;
        coll_s  = en1_i && en2_i && same_s && (wr1_s || wr2_s);
        if (coll_s && (coll_cnt_q != {CNT_WIDTH{1'b1}})) begin
            coll_cnt_d = coll_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            coll_cnt_d = coll_cnt_q;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr1_s) mem_q[addr1_i] <= word1_s;
            if (wr2_s) mem_q[addr2_i] <= word2_s;
        end
    end

    // First read stage plus collision tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data1_q  <= {DATA_WIDTH{1'b0}};
            s1_data2_q  <= {DATA_WIDTH{1'b0}};
            s1_valid1_q <= 1'b0;
            s1_valid2_q <= 1'b0;
            collision_q <= 1'b0;
            coll_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            s1_valid1_q <= en1_i;
            s1_valid2_q <= en2_i;
            if (en1_i) s1_data1_q <= resp1_s;
            if (en2_i) s1_data2_q <= resp2_s;
            collision_q <= coll_s;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data1_q, s2_data2_q;
        logic                  s2_valid1_q, s2_valid2_q;

        // Extra output stage; data only advances with its valid so it holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data1_q  <= {DATA_WIDTH{1'b0}};
                s2_data2_q  <= {DATA_WIDTH{1'b0}};
                s2_valid1_q <= 1'b0;
                s2_valid2_q <= 1'b0;
            end else begin
                s2_valid1_q <= s1_valid1_q;
                s2_valid2_q <= s1_valid2_q;
                if (s1_valid1_q) s2_data1_q <= s1_data1_q;
                if (s1_valid2_q) s2_data2_q <= s1_data2_q;
            end
        end

        assign rd_data1_o  = s2_data1_q;
        assign rd_data2_o  = s2_data2_q;
        assign rd_valid1_o = s2_valid1_q;
        assign rd_valid2_o = s2_valid2_q;
    end else begin : g_lat1
        assign rd_data1_o  = s1_data1_q;
        assign rd_data2_o  = s1_data2_q;
        assign rd_valid1_o = s1_valid1_q;
        assign rd_valid2_o = s1_valid2_q;
    end

    assign collision_o = collision_q;
    assign coll_cnt_o  = coll_cnt_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench: u0 = latency 1 / read-first / 16-bit counter,
// u1 = latency 2 / write-first / 2-bit counter, both on shared stimulus.
module tb_dp_ram_be;

    logic        clk;
    logic        rst;
    logic        en1, en2;
    logic [3:0]  we1, we2;
    logic [9:0]  a1, a2;
    logic [31:0] wd1, wd2;

    logic [31:0] u0_d1, u0_d2, u1_d1, u1_d2;
    logic        u0_v1, u0_v2, u1_v1, u1_v2, u0_col, u1_col;
    logic [15:0] u0_cnt;
    logic [1:0]  u1_cnt;

    int checks = 0;
    int errors = 0;

    dp_ram_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .RD_LATENCY(1), .RDW_MODE(0), .CNT_WIDTH(16)) u0 (
        .clk(clk), .rst(rst),
        .en1_i(en1), .we1_i(we1), .addr1_i(a1), .wr_data1_i(wd1),
        .rd_data1_o(u0_d1), .rd_valid1_o(u0_v1),
        .en2_i(en2), .we2_i(we2), .addr2_i(a2), .wr_data2_i(wd2),
        .rd_data2_o(u0_d2), .rd_valid2_o(u0_v2),
        .collision_o(u0_col), .coll_cnt_o(u0_cnt)
    );

    dp_ram_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                .RD_LATENCY(2), .RDW_MODE(1), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst(rst),
        .en1_i(en1), .we1_i(we1), .addr1_i(a1), .wr_data1_i(wd1),
        .rd_data1_o(u1_d1), .rd_valid1_o(u1_v1),
        .en2_i(en2), .we2_i(we2), .addr2_i(a2), .wr_data2_i(wd2),
        .rd_data2_o(u1_d2), .rd_valid2_o(u1_v2),
        .collision_o(u1_col), .coll_cnt_o(u1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en1 = 1'b0; we1 = 4'h0; a1 = 10'd0; wd1 = 32'h0;
        en2 = 1'b0; we2 = 4'h0; a2 = 10'd0; wd2 = 32'h0;
    endtask

    task automatic p1(input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
        en1 = 1'b1; a1 = a; we1 = we; wd1 = d;
    endtask

    task automatic p2(input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
        en2 = 1'b1; a2 = a; we2 = we; wd2 = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_u0_d1", u0_d1, 32'h0);
        chk("rst_u0_d2", u0_d2, 32'h0);
        chk("rst_u0_v", {30'd0, u0_v1, u0_v2}, 32'h0);
        chk("rst_u0_col", {31'd0, u0_col}, 32'h0);
        chk("rst_u0_cnt", {16'd0, u0_cnt}, 32'h0);
        chk("rst_u1_d1", u1_d1, 32'h0);
        chk("rst_u1_v", {30'd0, u1_v1, u1_v2}, 32'h0);
        chk("rst_u1_cnt", {30'd0, u1_cnt}, 32'h0);

        // Write then cross-port read of address 5
        p1(10'd5, 4'hF, 32'hDEADBEEF);
        step();
        chk("t1_u0_v1", {31'd0, u0_v1}, 32'h1);
        chk("t1_u1_v1", {31'd0, u1_v1}, 32'h0);
        idle(); p2(10'd5, 4'h0, 32'h0);
        step();
        chk("t1_u0_v2", {31'd0, u0_v2}, 32'h1);
        chk("t1_u0_d2", u0_d2, 32'hDEADBEEF);
        chk("t1_u0_v1_off", {31'd0, u0_v1}, 32'h0);
        chk("t1_u1_v1", {31'd0, u1_v1}, 32'h1);
        chk("t1_u1_wf_d1", u1_d1, 32'hDEADBEEF);
        chk("t1_u1_v2_early", {31'd0, u1_v2}, 32'h0);
        idle();
        step();
        chk("t1_u0_v2_pulse", {31'd0, u0_v2}, 32'h0);
        chk("t1_u0_d2_hold", u0_d2, 32'hDEADBEEF);
        chk("t1_u1_v2", {31'd0, u1_v2}, 32'h1);
        chk("t1_u1_d2", u1_d2, 32'hDEADBEEF);

        // Partial-lane write on address 7
        p1(10'd7, 4'hF, 32'h11223344);
        step();
        p1(10'd7, 4'b0101, 32'hAABBCCDD);
        step();
        chk("t2_u0_rf_resp", u0_d1, 32'h11223344);
        chk("t2_u1_prev", u1_d1, 32'h11223344);
        p1(10'd7, 4'h0, 32'h0);
        step();
        chk("t2_u0_read", u0_d1, 32'h11BB33DD);
        chk("t2_u1_wf_resp", u1_d1, 32'h11BB33DD);
        idle();
        step();
        chk("t2_u1_read", u1_d1, 32'h11BB33DD);

        // Write/write collision on address 9 (byte 3 preset to 0x99)
        p1(10'd9, 4'hF, 32'h99887766);
        step();
        p1(10'd9, 4'b0011, 32'h000000FF);
        p2(10'd9, 4'b0110, 32'h12345678);
        step();
        chk("t3_u0_col", {31'd0, u0_col}, 32'h1);
        chk("t3_u0_cnt", {16'd0, u0_cnt}, 32'h1);
        chk("t3_u1_cnt", {30'd0, u1_cnt}, 32'h1);
        idle(); p1(10'd9, 4'h0, 32'h0);
        step();
        chk("t3_col_pulse", {31'd0, u0_col}, 32'h0);
        chk("t3_u0_read", u0_d1, 32'h993456FF);
        idle();
        step();
        chk("t3_u1_read", u1_d1, 32'h993456FF);

        // Read/write collision on address 3
        p1(10'd3, 4'hF, 32'hCAFE0000);
        step();
        p1(10'd3, 4'h0, 32'h0);
        p2(10'd3, 4'hF, 32'h0000BEEF);
        step();
        chk("t4_u0_d1_old", u0_d1, 32'hCAFE0000);
        chk("t4_u0_col", {31'd0, u0_col}, 32'h1);
        chk("t4_u0_cnt", {16'd0, u0_cnt}, 32'h2);
        idle(); p1(10'd3, 4'h0, 32'h0);
        step();
        chk("t4_u0_col_once", {31'd0, u0_col}, 32'h0);
        chk("t4_u0_read_new", u0_d1, 32'h0000BEEF);
        chk("t4_u1_d1_old", u1_d1, 32'hCAFE0000);
        idle();
        step();
        chk("t4_u1_read_new", u1_d1, 32'h0000BEEF);

        // Counter saturation on the 2-bit instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_u1_cnt_rst", {30'd0, u1_cnt}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            p1(10'd0, 4'h0, 32'h0);
            p2(10'd0, 4'hF, 32'h0 + k);
            step();
            chk("t5_u1_cnt", {30'd0, u1_cnt}, (k > 3) ? 32'd3 : k);
            chk("t5_u0_cnt", {16'd0, u0_cnt}, k);
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_u1_cnt_clr", {30'd0, u1_cnt}, 32'h0);
        chk("t5_u0_cnt_clr", {16'd0, u0_cnt}, 32'h0);

        // Back-to-back reads with reset on the fourth request
        p1(10'd5, 4'h0, 32'h0);
        step();
        chk("t6_u1_v_a", {31'd0, u1_v1}, 32'h0);
        chk("t6_u0_d_a", u0_d1, 32'hDEADBEEF);
        p1(10'd7, 4'h0, 32'h0);
        step();
        chk("t6_u1_v_b", {31'd0, u1_v1}, 32'h1);
        chk("t6_u1_d_b", u1_d1, 32'hDEADBEEF);
        p1(10'd9, 4'h0, 32'h0);
        step();
        chk("t6_u1_v_c", {31'd0, u1_v1}, 32'h1);
        chk("t6_u1_d_c", u1_d1, 32'h11BB33DD);
        p1(10'd3, 4'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("t6_u1_v_rst", {31'd0, u1_v1}, 32'h0);
        chk("t6_u1_d_rst", u1_d1, 32'h0);
        chk("t6_u0_d_rst", u0_d1, 32'h0);
        step();
        chk("t6_u1_v_drop3", {31'd0, u1_v1}, 32'h0);
        chk("t6_u1_d_zero", u1_d1, 32'h0);
        step();
        chk("t6_u1_v_drop4", {31'd0, u1_v1}, 32'h0);
        chk("t6_u0_v_idle", {31'd0, u0_v1}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
